// File: rtl/serial_frame_rx.sv
// Serial frame receiver: oversamples an external bit clock in the CLK domain and
// assembles LSB-first frames. Optional even parity bit enabled by SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int FIELD_W     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               RCLK,
  input  logic               RDATA,
  input  logic               RSYNC,
  output logic [DATA_W-1:0]  DATA_OUT,
  output logic               DATA_VALID,
  output logic [FIELD_W-1:0] COLOR,
  output logic [FIELD_W-1:0] SIZE,
  output logic               FRAME_ERR,
  output logic               PARITY_ERR,
  output logic [15:0]        FRAME_CNT
);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, RECV} state_t;

  // Bit order in the synchronizer vectors: 0 = RCLK, 1 = RDATA, 2 = RSYNC.
  // RDATA shares the RCLK pipeline depth so sampled data stays aligned to the edge.
  logic [2:0] async_in;
  logic [2:0] meta_reg;
  logic [2:0] sync_reg;
  logic       rclk_prev_reg;

  assign async_in = {RSYNC, RDATA, RCLK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= async_in[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET_N) rclk_prev_reg <= 1'b0;
    else          rclk_prev_reg <= sync_reg[0];
  end

  logic bit_edge;
  logic rdata_sync;
  logic rsync_sync;

  assign bit_edge   = sync_reg[0] & ~rclk_prev_reg;
  assign rdata_sync = sync_reg[1];
  assign rsync_sync = sync_reg[2];

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [TCNT_W-1:0]     tcnt_reg, tcnt_next;
  logic [FRAME_LEN-1:0]  shift_reg, shift_next;
  logic                  frame_done;
  logic                  load;
  logic                  frame_err_next;
  logic                  parity_err_next;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      tcnt_reg  <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tcnt_reg  <= tcnt_next;
      shift_reg <= shift_next;
    end
  end

  // Priority: RSYNC restart, then bit edge, then timeout.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    tcnt_next       = tcnt_reg;
    shift_next      = shift_reg;
    frame_done      = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    load            = 1'b0;

    if (rsync_sync) begin
      state_next = IDLE;
      idx_next   = '0;
      tcnt_next  = '0;
    end else if (bit_edge) begin
      tcnt_next  = '0;
      // Bits arrive LSB first, so shifting in at the top leaves bit 0 at position 0.
      shift_next = {rdata_sync, shift_reg[FRAME_LEN-1:1]};
      if (state_reg == IDLE) begin
        state_next = RECV;
        idx_next   = IDX_W'(1);
      end else if (idx_reg == LAST_IDX) begin
        state_next = IDLE;
        idx_next   = '0;
        frame_done = 1'b1;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end else if (state_reg == RECV) begin
      if (tcnt_reg == TCNT_MAX) begin
        state_next     = IDLE;
        idx_next       = '0;
        tcnt_next      = '0;
        frame_err_next = 1'b1;
      end else begin
        tcnt_next = tcnt_reg + TCNT_W'(1);
      end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    if (frame_done) begin
      if (^shift_next) parity_err_next = 1'b1;
      else             load            = 1'b1;
    end
`else
    load = frame_done;
`endif
  end

  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              frame_err_reg;
  logic [15:0]       frame_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      data_out_reg   <= '1;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      data_valid_reg <= load;
      frame_err_reg  <= frame_err_next;
      if (load) begin
        data_out_reg <= shift_next[DATA_W-1:0];
        if (frame_cnt_reg != 16'hFFFF) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic parity_err_reg;
  always_ff @(posedge CLK) begin
    if (!RESET_N) parity_err_reg <= 1'b0;
    else          parity_err_reg <= parity_err_next;
  end
  assign PARITY_ERR = parity_err_reg;
`else
  logic unused_parity;
  assign unused_parity = parity_err_next;
  assign PARITY_ERR    = 1'b0;
`endif

  assign DATA_OUT   = data_out_reg;
  assign DATA_VALID = data_valid_reg;
  assign FRAME_ERR  = frame_err_reg;
  assign FRAME_CNT  = frame_cnt_reg;
  assign COLOR      = data_out_reg[FIELD_W-1:0];
  assign SIZE       = data_out_reg[2*FIELD_W-1:FIELD_W];

endmodule
